// File: rtl/flow_control_receiver.sv
// Receive endpoint of a credit-based link: buffers incoming flits in a FIFO,
// hands them downstream with valid/ready, and returns one credit per freed slot.
module flow_control_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic                         credit_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         owed;
  logic [CW-1:0]         avail;
  logic                  full;
  logic                  push;
  logic                  pop;

  // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    full  = (occupancy == FULL_COUNT);
    pop   = valid_out && ready_out;
    push  = valid_in && (!full || pop);
    avail = owed + CW'(pop);
  end

  assign valid_out = (occupancy != '0);
  // Gate the head with valid so the unreset storage never leaks X after reset.
  assign data_out  = valid_out ? mem[rd_ptr] : '0;

  // NOTE: storage carries no reset; entries are only readable after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      owed       <= FULL_COUNT;
      credit_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
      // Reset value of owed is the initial advertisement; pops queue behind it.
      credit_out <= (avail != '0);
      owed       <= avail - CW'(avail != '0);
      if (valid_in && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flow_control_receiver.sv
// Directed bench for flow_control_receiver: table-driven vectors plus hand-written
// multi-cycle sequences and a credit-obeying transmitter model with scoreboard.
module tb_flow_control_receiver;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic          credit_out;
  logic [3:0]    occupancy;
  logic          overflow;

  int   errors = 0;
  int   checks = 0;
  logic inv_en = 1'b0;

  always #5 clk = ~clk;

  flow_control_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .credit_out (credit_out),
    .occupancy  (occupancy),
    .overflow   (overflow)
  );

  // Credit conservation; switched off only while the bench deliberately pushes without credit.
  property p_credit_invariant;
    @(posedge clk) disable iff (!rst_n || !inv_en)
      (32'(occupancy) + 32'(dut.owed) + 32'(credit_out)) <= DEPTH;
  endproperty
  assert property (p_credit_invariant)
    else begin
      errors++;
      $display("FAIL invariant: occupancy=%0d owed=%0d credit_out=%0d exceeds %0d",
               occupancy, dut.owed, credit_out, DEPTH);
    end

  typedef struct {
    logic          vin;
    logic [DW-1:0] din;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_credit;
    logic [3:0]    e_occ;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = '0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_ticks(input int n);
    valid_in  = 1'b0;
    ready_out = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] drain_exp[8];
    logic [DW-1:0] front;
    int            credit_cnt;
    int            first_credit;
    int            last_credit;
    int            tx_credits;
    int            seq;

    // ---------------- asynchronous reset state ----------------
    rst_n     = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = '0;
    #1;
    rst_n = 1'b0;
    #2;
    check("reset.valid_out",  32'(valid_out),  32'd0);
    check("reset.data_out",   32'(data_out),   32'd0);
    check("reset.credit_out", 32'(credit_out), 32'd0);
    check("reset.occupancy",  32'(occupancy),  32'd0);
    check("reset.overflow",   32'(overflow),   32'd0);
    check("reset.owed",       32'(dut.owed),   32'(DEPTH));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    inv_en = 1'b1;

    // ---------------- table: init credits, fill, drop, drain ----------------
    for (int k = 1; k <= 8; k++) vecs.push_back('{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 4'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0});
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{1'b1, 16'(i), 1'b0, 1'b1, 16'h0001, 1'b0, 4'(i), 1'b0});
    vecs.push_back('{1'b1, 16'hDEAD, 1'b0, 1'b1, 16'h0001, 1'b0, 4'd8, 1'b1});
    for (int j = 1; j <= 7; j++)
      vecs.push_back('{1'b0, 16'h0, 1'b1, 1'b1, 16'(j + 1), 1'b1, 4'(8 - j), 1'b1});
    vecs.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 4'd0, 1'b1});
    vecs.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 1'b1});

    foreach (vecs[i]) begin
      valid_in  = vecs[i].vin;
      data_in   = vecs[i].din;
      ready_out = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d.valid_out",  i), 32'(valid_out),  32'(vecs[i].e_valid));
      check($sformatf("vec%0d.data_out",   i), 32'(data_out),   32'(vecs[i].e_data));
      check($sformatf("vec%0d.credit_out", i), 32'(credit_out), 32'(vecs[i].e_credit));
      check($sformatf("vec%0d.occupancy",  i), 32'(occupancy),  32'(vecs[i].e_occ));
      check($sformatf("vec%0d.overflow",   i), 32'(overflow),   32'(vecs[i].e_ovf));
    end

    // ---------------- full FIFO with same-cycle push and pop ----------------
    do_reset();
    inv_en = 1'b1;
    idle_ticks(9);
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1;
      data_in  = 16'(16'h0011 + i);
      tick();
    end
    check("full.occupancy", 32'(occupancy), 32'd8);
    inv_en    = 1'b0;
    valid_in  = 1'b1;
    data_in   = 16'h00AA;
    ready_out = 1'b1;
    tick();
    check("pushpop.occupancy",  32'(occupancy),  32'd8);
    check("pushpop.overflow",   32'(overflow),   32'd0);
    check("pushpop.data_out",   32'(data_out),   32'h0012);
    check("pushpop.credit_out", 32'(credit_out), 32'd1);
    valid_in = 1'b0;
    for (int k = 0; k < 7; k++) drain_exp[k] = 16'(16'h0012 + k);
    drain_exp[7] = 16'h00AA;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d.data_out", k), 32'(data_out), 32'(drain_exp[k]));
      tick();
    end
    check("drain.valid_out", 32'(valid_out), 32'd0);
    check("drain.overflow",  32'(overflow),  32'd0);

    // ---------------- pops during the initial credit window ----------------
    do_reset();
    inv_en       = 1'b1;
    credit_cnt   = 0;
    first_credit = 0;
    last_credit  = 0;
    for (int t = 1; t <= 14; t++) begin
      valid_in  = (t == 2) || (t == 3);
      data_in   = (t == 2) ? 16'h0A01 : 16'h0A02;
      ready_out = (t == 3) || (t == 4);
      if (t == 3) check("window.head_a", 32'(data_out), 32'h0A01);
      if (t == 4) check("window.head_b", 32'(data_out), 32'h0A02);
      tick();
      if (credit_out) begin
        credit_cnt++;
        if (first_credit == 0) first_credit = t;
        last_credit = t;
      end
    end
    check("window.credit_count", 32'(credit_cnt),   32'd10);
    check("window.first_credit", 32'(first_credit), 32'd1);
    check("window.last_credit",  32'(last_credit),  32'd10);
    check("window.owed",         32'(dut.owed),     32'd0);
    check("window.occupancy",    32'(occupancy),    32'd0);

    // ---------------- credit-obeying transmitter with random ready ----------------
    do_reset();
    inv_en     = 1'b1;
    tx_credits = 0;
    seq        = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (credit_out) tx_credits++;
      check("rand.valid_out", 32'(valid_out), 32'(exp_q.size() != 0));
      ready_out = ($urandom_range(0, 3) != 0);
      if (valid_out && ready_out && exp_q.size() != 0) begin
        front = exp_q.pop_front();
        check("rand.data_out", 32'(data_out), 32'(front));
      end
      if (tx_credits > 0 && $urandom_range(0, 1) == 1) begin
        valid_in = 1'b1;
        data_in  = 16'(seq);
        exp_q.push_back(16'(seq));
        seq++;
        tx_credits--;
      end else begin
        valid_in = 1'b0;
      end
      tick();
    end
    valid_in  = 1'b0;
    ready_out = 1'b0;
    check("rand.overflow",  32'(overflow),  32'd0);
    check("rand.occupancy", 32'(occupancy), 32'(exp_q.size()));
    check("rand.progress",  32'(seq > 200), 32'd1);

    // ---------------- reset asserted mid-operation ----------------
    if (exp_q.size() == 0) begin
      valid_in = 1'b1;
      data_in  = 16'h0BEE;
      tick();
      valid_in = 1'b0;
    end
    check("midrst.pre_valid", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.valid_out",  32'(valid_out),  32'd0);
    check("midrst.data_out",   32'(data_out),   32'd0);
    check("midrst.occupancy",  32'(occupancy),  32'd0);
    check("midrst.credit_out", 32'(credit_out), 32'd0);
    check("midrst.owed",       32'(dut.owed),   32'(DEPTH));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("midrst.restart_credit", 32'(credit_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
